beam_power_trigger: RTL and testbench
=====================================

BEAM_POWER_TRIGGER -- requirements
Module: beam_power_trigger

Interface
REQ-001 The block SHALL have parameter NSAMP, default 8, giving the samples per clock in the squared-beam word.
REQ-002 The block SHALL have parameter SQBITS, default 14, giving the unsigned width of each squared sample.
REQ-003 The block SHALL have parameter NWIN, default 4, giving the window length in clocks (power window = NWIN*NSAMP samples).
REQ-004 The block SHALL have parameter HOLDOFF_CLKS, default 16, giving the post-trigger dead time in clocks.
REQ-005 The block SHALL have localparam POWBITS = SQBITS + clog2(NSAMP) + clog2(NWIN), which is 19 with the defaults.
REQ-006 The block SHALL have one clock and an asynchronous active-high reset: clk_i, input, 1 bit, sole clock; rst_i, input, 1 bit, asynchronous active-high reset.
REQ-007 The block SHALL have port sq_i, input, NSAMP*SQBITS bits: unsigned squared beam samples, sample j at [SQBITS*j +: SQBITS], new word every clock.
REQ-008 The block SHALL have ports thresh_i, input, POWBITS bits (new threshold), thresh_valid_i, input, 1 bit (threshold offered), and thresh_ready_o, output, 1 bit (threshold accepted when high with valid).
REQ-009 The block SHALL have port mask_i, input, 1 bit, which inhibits trigger generation while high.
REQ-010 The block SHALL have port cnt_clr_i, input, 1 bit, a synchronous clear of trig_count_o.
REQ-011 The block SHALL have ports power_o, output, POWBITS bits (current window power), trig_o, output, 1 bit (one-clock trigger pulse), and trig_count_o, output, 16 bits (trigger counter).

Function
REQ-012 Stage 1 SHALL register the clock sum S[n], the unsigned sum of all NSAMP samples of sq_i, exact with no truncation.
REQ-013 Stage 2 SHALL register power_o = S[n] + S[n-1] + ... + S[n-NWIN+1], updated every clock as power + S[n] - S[n-NWIN] using an NWIN-deep delay line of S.
REQ-014 Latency SHALL be exactly 2 clocks from sq_i to a power_o that includes that word, and the sum SHALL never overflow for any input.
REQ-015 The FSM SHALL have states ARMED, FIRE and HOLDOFF.
REQ-016 In ARMED, when power_o > threshold (strictly greater) and mask_i is low, the FSM SHALL go to FIRE on the next edge; otherwise it stays in ARMED.
REQ-017 FIRE SHALL last exactly one clock with trig_o = 1, then go to HOLDOFF, loading the holdoff counter with HOLDOFF_CLKS.
REQ-018 HOLDOFF SHALL last exactly HOLDOFF_CLKS clocks regardless of mask_i or power, then go to ARMED; with power held above threshold, trig_o pulses SHALL be spaced HOLDOFF_CLKS+2 clocks apart.
REQ-019 trig_o SHALL be high only in FIRE.
REQ-020 Masking SHALL only block the ARMED->FIRE transition and SHALL NOT abort FIRE or HOLDOFF.
REQ-021 thresh_ready_o SHALL be high in ARMED and HOLDOFF and low in FIRE.
REQ-022 An accepted threshold SHALL be used for the comparison starting the clock after acceptance, and an unaccepted offer SHALL have no effect.
REQ-023 trig_count_o SHALL increment on entry to FIRE and saturate at 0xFFFF.
REQ-024 If cnt_clr_i coincides with a FIRE entry, clear SHALL win and the count SHALL be 0.

Reset
REQ-025 While rst_i is high (asynchronous assert), outputs SHALL be: power_o = 0, trig_o = 0, trig_count_o = 0, thresh_ready_o = 1.
REQ-026 Reset SHALL clear the stage-1 register, the delay line, and the window sum to 0, and set the FSM to ARMED and the holdoff counter to 0.
REQ-027 Reset SHALL set the threshold register to all-ones, so the block cannot trigger until a threshold is written.
REQ-028 Reset asserted mid-FIRE or mid-HOLDOFF SHALL return the block to ARMED with the zeroed state above.
REQ-029 Reset release SHALL be synchronised to clk_i, and the first stage-1 capture SHALL be on the first edge after deassertion.

Structure
REQ-030 NSAMP, SQBITS, POWBITS and the FSM state enum SHALL live in shared package pueo_trigger_pkg.
REQ-031 The sliding window (REQ-013) SHALL be sub-module beam_power_window, with parameters NSAMP/SQBITS/NWIN and ports clk_i, rst_i, sq_i, power_o.
REQ-032 The FSM, threshold handshake and counter SHALL be in the top module.

Verification
REQ-033 After reset, write threshold 3000, then drive every sample = 100 constantly: power_o SHALL read 800/1600/2400/3200 on the 2nd-5th clocks, and a single trig_o SHALL occur the clock after power_o = 3200.
REQ-034 Hold the REQ-033 stimulus: trig_o pulses SHALL be 18 clocks apart and trig_count_o SHALL increment by 1 per pulse.
REQ-035 Set threshold = 3200 with power steady at 3200: no trigger SHALL occur; then write 3199: trig_o SHALL assert 2 clocks after acceptance.
REQ-036 Raise mask_i during HOLDOFF and keep it high: the holdoff SHALL complete and no new FIRE SHALL occur; drop mask_i: FIRE SHALL follow 1 clock later.
REQ-037 Drive all samples = 0x3FFF: power_o SHALL equal 4*8*16383 = 524256 without wrap; assert rst_i mid-HOLDOFF: all outputs SHALL be at reset values immediately, with no trigger until a threshold is rewritten.
REQ-038 Force trig_count_o to 0xFFFF, then cause a trigger: the count SHALL hold at 0xFFFF; assert cnt_clr_i on a FIRE entry: the count SHALL be 0.

Source files
------------

// File: rtl/pueo_trigger_pkg.sv
// Shared constants and FSM state type for the beam power trigger.
package pueo_trigger_pkg;

    localparam int NSAMP    = 8;
    localparam int SQBITS   = 14;
    localparam int NWIN_DEF = 4;
    localparam int POWBITS  = SQBITS + $clog2(NSAMP) + $clog2(NWIN_DEF);
    localparam int CNTBITS  = 16;

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_FIRE    = 2'd1,
        ST_HOLDOFF = 2'd2
    } trig_state_e;

endpackage

// File: rtl/beam_power_window.sv
// Two-stage beam power: per-clock sample sum, then a running NWIN-clock window sum.
module beam_power_window #(
    parameter int  NSAMP   = pueo_trigger_pkg::NSAMP,
    parameter int  SQBITS  = pueo_trigger_pkg::SQBITS,
    parameter int  NWIN    = pueo_trigger_pkg::NWIN_DEF,
    localparam int SUMBITS = SQBITS + $clog2(NSAMP),
    localparam int POWBITS = SUMBITS + $clog2(NWIN)
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NSAMP*SQBITS-1:0] sq_i,
    output logic [POWBITS-1:0]      power_o
);

    logic [SUMBITS-1:0] w_clk_sum;
    logic [SUMBITS-1:0] r_clk_sum;
    logic [SUMBITS-1:0] r_dly [NWIN];
    logic [POWBITS-1:0] r_power;

    always_comb begin
        w_clk_sum = '0;
        for (int j = 0; j < NSAMP; j++) begin
            w_clk_sum = w_clk_sum + SUMBITS'(sq_i[SQBITS*j +: SQBITS]);
        end
    end

    // r_dly[NWIN-1] is the clock sum leaving the window; the running sum stays
    // exact because its true value always fits in POWBITS.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_clk_sum <= '0;
            r_power   <= '0;
            for (int k = 0; k < NWIN; k++) begin
                r_dly[k] <= '0;
            end
        end else begin
            r_clk_sum <= w_clk_sum;
            r_dly[0]  <= r_clk_sum;
            for (int k = 1; k < NWIN; k++) begin
                r_dly[k] <= r_dly[k-1];
            end
            r_power <= r_power + POWBITS'(r_clk_sum) - POWBITS'(r_dly[NWIN-1]);
        end
    end

    assign power_o = r_power;

endmodule

// File: rtl/beam_power_trigger.sv
// Beam power threshold trigger: window power, one-clock trigger pulse with
// holdoff, runtime threshold handshake and a saturating trigger counter.
module beam_power_trigger #(
    parameter int  NSAMP        = pueo_trigger_pkg::NSAMP,
    parameter int  SQBITS       = pueo_trigger_pkg::SQBITS,
    parameter int  NWIN         = pueo_trigger_pkg::NWIN_DEF,
    parameter int  HOLDOFF_CLKS = 16,
    localparam int POWBITS      = SQBITS + $clog2(NSAMP) + $clog2(NWIN)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NSAMP*SQBITS-1:0]       sq_i,
    input  logic [POWBITS-1:0]            thresh_i,
    input  logic                          thresh_valid_i,
    output logic                          thresh_ready_o,
    input  logic                          mask_i,
    input  logic                          cnt_clr_i,
    output logic [POWBITS-1:0]            power_o,
    output logic                          trig_o,
    output logic [15:0]                   trig_count_o,
    output pueo_trigger_pkg::trig_state_e state_o
);

    import pueo_trigger_pkg::*;

    localparam int HOCNTBITS = (HOLDOFF_CLKS < 2) ? 1 : $clog2(HOLDOFF_CLKS + 1);
    localparam logic [HOCNTBITS-1:0] HOLDOFF_LOAD = HOCNTBITS'(HOLDOFF_CLKS);
    localparam logic [HOCNTBITS-1:0] HO_ONE       = HOCNTBITS'(1);

    trig_state_e          r_state;
    trig_state_e          w_state_nxt;
    logic [HOCNTBITS-1:0] r_ho_cnt;
    logic [HOCNTBITS-1:0] w_ho_cnt_nxt;
    logic [POWBITS-1:0]   r_thresh;
    logic [POWBITS-1:0]   w_power;
    logic [15:0]          r_trig_count;
    logic                 w_fire_entry;
    logic                 w_thresh_accept;

    beam_power_window #(
        .NSAMP  (NSAMP),
        .SQBITS (SQBITS),
        .NWIN   (NWIN)
    ) u_window (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .sq_i    (sq_i),
        .power_o (w_power)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= ST_ARMED;
            r_ho_cnt <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_ho_cnt <= w_ho_cnt_nxt;
        end
    end

    // Mask only gates leaving ARMED; FIRE and HOLDOFF always run to completion.
    always_comb begin
        w_state_nxt  = r_state;
        w_ho_cnt_nxt = r_ho_cnt;
        w_fire_entry = 1'b0;
        case (r_state)
            ST_ARMED: begin
                if ((w_power > r_thresh) && !mask_i) begin
                    w_state_nxt  = ST_FIRE;
                    w_fire_entry = 1'b1;
                end
            end
            ST_FIRE: begin
                w_state_nxt  = ST_HOLDOFF;
                w_ho_cnt_nxt = HOLDOFF_LOAD;
            end
            ST_HOLDOFF: begin
                if (r_ho_cnt <= HO_ONE) begin
                    w_state_nxt  = ST_ARMED;
                    w_ho_cnt_nxt = '0;
                end else begin
                    w_ho_cnt_nxt = r_ho_cnt - HO_ONE;
                end
            end
            default: begin
                w_state_nxt  = ST_ARMED;
                w_ho_cnt_nxt = '0;
            end
        endcase
    end

    // Threshold handshake: a word transfers on a clock edge where both
    // thresh_valid_i and thresh_ready_o are high; the offer may be held or
    // dropped freely otherwise. Ready is low only during the FIRE clock.
    assign w_thresh_accept = thresh_valid_i && thresh_ready_o;

    // All-ones after reset so nothing can exceed it until software writes one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_thresh <= '1;
        end else if (w_thresh_accept) begin
            r_thresh <= thresh_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_trig_count <= '0;
        end else if (cnt_clr_i) begin
            r_trig_count <= '0;
        end else if (w_fire_entry && (r_trig_count != 16'hFFFF)) begin
            r_trig_count <= r_trig_count + 16'd1;
        end
    end

    assign thresh_ready_o = (r_state != ST_FIRE);
    assign trig_o         = (r_state == ST_FIRE);
    assign power_o        = w_power;
    assign trig_count_o   = r_trig_count;
    assign state_o        = r_state;

endmodule

// File: tb/tb_beam_power_trigger.sv
// Directed and randomized bench for beam_power_trigger against a window/timestamp reference model.
module tb_beam_power_trigger;
  import pueo_trigger_pkg::*;

  localparam int NS  = 8;
  localparam int SQB = 14;
  localparam int NW  = 4;
  localparam int HO  = 16;
  localparam int PB  = 19;

  // clock / reset / DUT
  logic              clk = 1'b0;
  logic              rst_i = 1'b0;
  logic [NS*SQB-1:0] sq_i = '0;
  logic [PB-1:0]     thresh_i = '0;
  logic              thresh_valid_i = 1'b0;
  logic              thresh_ready_o;
  logic              mask_i = 1'b0;
  logic              cnt_clr_i = 1'b0;
  logic [PB-1:0]     power_o;
  logic              trig_o;
  logic [15:0]       trig_count_o;
  trig_state_e       state_dbg;

  always #5 clk = ~clk;

  beam_power_trigger #(
    .NSAMP(NS), .SQBITS(SQB), .NWIN(NW), .HOLDOFF_CLKS(HO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .sq_i(sq_i),
    .thresh_i(thresh_i), .thresh_valid_i(thresh_valid_i), .thresh_ready_o(thresh_ready_o),
    .mask_i(mask_i), .cnt_clr_i(cnt_clr_i),
    .power_o(power_o), .trig_o(trig_o), .trig_count_o(trig_count_o), .state_o(state_dbg)
  );

  int checks = 0;
  int errors = 0;

  // reference model: window of per-clock sums plus a "re-armed at edge" timestamp
  int unsigned m_s1;
  int unsigned m_win[$];
  int unsigned m_power;
  int unsigned m_thr;
  int unsigned m_count;
  bit          m_trig;
  longint      m_ec = 0;
  longint      m_armed_from;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0;
    m_win.delete();
    repeat (NW) m_win.push_back(0);
    m_power = 0;
    m_thr = (1 << PB) - 1;
    m_count = 0;
    m_trig = 1'b0;
    m_armed_from = 0;
  endtask

  task automatic model_edge();
    bit fire;
    int unsigned s;
    m_ec++;
    fire = (m_ec >= m_armed_from) && (m_power > m_thr) && !mask_i;
    if (thresh_valid_i && !m_trig) m_thr = 32'(thresh_i);
    if (cnt_clr_i) m_count = 0;
    else if (fire && m_count < 65535) m_count++;
    if (fire) m_armed_from = m_ec + HO + 2;
    m_trig = fire;
    m_win.push_back(m_s1);
    void'(m_win.pop_front());
    m_power = 0;
    foreach (m_win[i]) m_power += m_win[i];
    s = 0;
    for (int j = 0; j < NS; j++) s += 32'(sq_i[SQB*j +: SQB]);
    m_s1 = s;
  endtask

  task automatic compare_all();
    chk("power", 32'(power_o), m_power);
    chk("trig", 32'(trig_o), 32'(m_trig));
    chk("count", 32'(trig_count_o), m_count);
    chk("ready", 32'(thresh_ready_o), 32'(!m_trig));
    chk("state_fire", 32'(state_dbg == ST_FIRE), 32'(m_trig));
  endtask

  // driver tasks
  task automatic step();
    @(posedge clk);
    if (!rst_i) model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_all(input int unsigned v);
    for (int j = 0; j < NS; j++) sq_i[SQB*j +: SQB] = SQB'(v);
  endtask

  task automatic write_thr(input int unsigned v);
    bit acc;
    thresh_i = PB'(v);
    thresh_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      acc = !m_trig;
      step();
      if (acc) break;
    end
    thresh_valid_i = 1'b0;
  endtask

  task automatic wait_trig(input string tag, input int budget, output int n);
    n = 0;
    for (int i = 1; i <= budget; i++) begin
      step();
      if (trig_o) begin
        n = i;
        break;
      end
    end
    chk(tag, 32'(trig_o), 32'd1);
  endtask

  task automatic count_trigs(input int cycles, output int ntr);
    ntr = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (trig_o) ntr++;
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int ntr;

    // reset state
    model_reset();
    #1 rst_i = 1'b1;
    #1;
    compare_all();
    step();
    step();
    rst_i = 1'b0;

    // ramp of constant samples and first trigger
    write_thr(3000);
    set_all(100);
    for (int k = 1; k <= 5; k++) begin
      step();
      if (k >= 2) chk("ramp_power", 32'(power_o), 32'(800 * (k - 1)));
    end
    step();
    chk("first_trig", 32'(trig_o), 32'd1);
    chk("first_count", 32'(trig_count_o), 32'd1);

    // repeated triggers while power stays high
    for (int r = 0; r < 2; r++) begin
      wait_trig("spacing_wait", 30, n);
      chk("spacing", 32'(n), 32'd18);
      chk("count_step", 32'(trig_count_o), 32'(2 + r));
    end

    // threshold equal to power must not trigger; one below fires two clocks later
    write_thr(3200);
    count_trigs(40, ntr);
    chk("eq_no_trig", 32'(ntr), 32'd0);
    thresh_i = PB'(3199);
    thresh_valid_i = 1'b1;
    step();
    thresh_valid_i = 1'b0;
    chk("thr_acc_no_trig_yet", 32'(trig_o), 32'd0);
    step();
    chk("thr_trig_2clk", 32'(trig_o), 32'd1);

    // mask raised in holdoff
    step();
    mask_i = 1'b1;
    count_trigs(40, ntr);
    chk("mask_no_trig", 32'(ntr), 32'd0);
    chk("mask_armed", 32'(state_dbg == ST_ARMED), 32'd1);
    mask_i = 1'b0;
    step();
    chk("unmask_trig", 32'(trig_o), 32'd1);

    // counter saturation and clear-wins
    force dut.r_trig_count = 16'hFFFF;
    #1;
    release dut.r_trig_count;
    m_count = 65535;
    wait_trig("sat_wait", 30, n);
    chk("sat_count", 32'(trig_count_o), 32'd65535);
    repeat (17) step();
    cnt_clr_i = 1'b1;
    step();
    cnt_clr_i = 1'b0;
    chk("clr_fire_trig", 32'(trig_o), 32'd1);
    chk("clr_wins", 32'(trig_count_o), 32'd0);

    // full-scale samples, then reset during holdoff
    set_all(16383);
    repeat (6) step();
    chk("max_power", 32'(power_o), 32'd524256);
    wait_trig("max_wait", 30, n);
    repeat (3) step();
    #2 rst_i = 1'b1;
    #1;
    model_reset();
    compare_all();
    chk("rst_power", 32'(power_o), 32'd0);
    chk("rst_trig", 32'(trig_o), 32'd0);
    chk("rst_count", 32'(trig_count_o), 32'd0);
    chk("rst_ready", 32'(thresh_ready_o), 32'd1);
    step();
    step();
    rst_i = 1'b0;
    count_trigs(40, ntr);
    chk("no_trig_after_rst", 32'(ntr), 32'd0);
    write_thr(500000);
    wait_trig("rewrite_trig", 10, n);

    // randomized traffic
    for (int c = 0; c < 500; c++) begin
      for (int j = 0; j < NS; j++)
        sq_i[SQB*j +: SQB] = ($urandom_range(0, 3) == 0) ? SQB'($urandom_range(0, 16383))
                                                          : SQB'($urandom_range(6000, 10000));
      mask_i = ($urandom_range(0, 7) == 0);
      cnt_clr_i = ($urandom_range(0, 31) == 0);
      thresh_valid_i = ($urandom_range(0, 9) == 0);
      thresh_i = PB'($urandom_range(200000, 330000));
      if (c == 250) begin
        #2 rst_i = 1'b1;
        #1;
        model_reset();
        compare_all();
        step();
        rst_i = 1'b0;
      end
      step();
    end
    mask_i = 1'b0;
    cnt_clr_i = 1'b0;
    thresh_valid_i = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
